// File: rtl/s_mem_writer.sv
// S memory write controller: streams STP coefficients into a polynomial slot
// and zero-fills the whole memory on RST.
module s_mem_writer #(
    parameter int s_size    = 88,
    parameter int word_size = 16,
    parameter int n_slots   = 8,
    parameter int slot_len  = 11,
    localparam int AW = $clog2(s_size),
    localparam int SW = (n_slots > 1) ? $clog2(n_slots) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           instr,
    input  logic [SW-1:0]        slot,
    input  logic [3:0]           degree,
    input  logic [word_size-1:0] coef_data,
    input  logic                 coef_valid,
    output logic                 coef_ready,
    output logic                 wr_en_S,
    output logic [AW-1:0]        wr_addr_S,
    output logic [word_size-1:0] wr_data_S,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [1:0] I_STP = 2'b00;
    localparam logic [1:0] I_RST = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR, DONE} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        count_q, count_d;
    logic [AW-1:0]        base_q, base_d;
    logic [3:0]           last_q, last_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [word_size-1:0] wr_data_q, wr_data_d;
    logic                 error_q, error_d;

    logic stp_ok;
    logic hs;
    logic last_hit;
    logic clear_end;

    // Bounds are checked at 32 bits so a narrow slot field cannot wrap.
    assign stp_ok    = (32'(slot) < n_slots) && (32'(degree) < slot_len);
    assign hs        = coef_valid && coef_ready;
    assign last_hit  = (count_q == AW'(last_q));
    assign clear_end = (count_q == AW'(s_size - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && instr == I_STP && stp_ok) begin
                    state_d = LOAD;
                end else if (start && instr == I_RST) begin
                    state_d = CLEAR;
                end
            end
            LOAD: begin
                if (hs && last_hit) begin
                    state_d = DONE;
                end
            end
            CLEAR: begin
                if (clear_end) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        coef_ready = (state_q == LOAD);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
    end

    always_comb begin
        count_d   = count_q;
        base_d    = base_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        error_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && instr == I_STP) begin
                    if (stp_ok) begin
                        base_d  = AW'(32'(slot) * slot_len);
                        last_d  = degree;
                        count_d = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (start && instr == I_RST) begin
                    count_d = '0;
                end
            end
            LOAD: begin
                if (hs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = base_q + count_q;
                    wr_data_d = coef_data;
                    count_d   = count_q + 1'b1;
                end
            end
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = count_q;
                wr_data_d = '0;
                count_d   = count_q + 1'b1;
            end
            DONE: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            base_q    <= '0;
            last_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            base_q    <= base_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            error_q   <= error_d;
        end
    end

    assign wr_en_S   = wr_en_q;
    assign wr_addr_S = wr_addr_q;
    assign wr_data_S = wr_data_q;
    assign error     = error_q;

endmodule

// File: tb/tb_s_mem_writer.sv
// Directed bench for s_mem_writer with a write scoreboard.
module tb_s_mem_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2, coef_valid;
    logic [1:0]  instr;
    logic [2:0]  slot;
    logic [3:0]  degree;
    logic [15:0] coef_data;

    logic        coef_ready, wr_en_S, busy, done, error;
    logic [6:0]  wr_addr_S;
    logic [15:0] wr_data_S;

    logic        coef_ready2, wr_en2, busy2, done2, error2;
    logic [6:0]  wr_addr2;
    logic [15:0] wr_data2;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    logic [22:0] exp_q[$];

    s_mem_writer u_dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .slot(slot), .degree(degree), .coef_data(coef_data),
        .coef_valid(coef_valid), .coef_ready(coef_ready),
        .wr_en_S(wr_en_S), .wr_addr_S(wr_addr_S),
        .wr_data_S(wr_data_S), .busy(busy), .done(done),
        .error(error)
    );

    // Five-slot variant so that out-of-range slot numbers are encodable.
    s_mem_writer #(
        .s_size(80), .word_size(16), .n_slots(5), .slot_len(16)
    ) u_dut5 (
        .clk(clk), .rst(rst), .start(start2), .instr(instr),
        .slot(slot), .degree(degree), .coef_data(coef_data),
        .coef_valid(coef_valid), .coef_ready(coef_ready2),
        .wr_en_S(wr_en2), .wr_addr_S(wr_addr2),
        .wr_data_S(wr_data2), .busy(busy2), .done(done2),
        .error(error2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] e;
        if (done === 1'b1) done_cnt++;
        if (wr_en_S === 1'b1) begin
            wr_cnt++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            chk("wr", {9'b0, wr_addr_S, wr_data_S}, {9'b0, e});
        end
    end

    task automatic stp(input int s, input int d, input bit tog,
                       input int exp_len);
        int i = 0;
        int n = 0;
        int d0 = done_cnt;
        logic [15:0] v;
        start = 1'b1;
        instr = 2'b00;
        slot = 3'(s);
        degree = 4'(d);
        @(negedge clk);
        start = 1'b0;
        chk("stp_ready1", coef_ready, 1);
        chk("stp_busy1", busy, 1);
        while (i <= d && n < 100) begin
            v = 16'((s << 12) | ((i + 1) * 16'h0011));
            coef_valid = tog ? ((n % 2) == 0) : 1'b1;
            coef_data = v;
            if (coef_valid && coef_ready) begin
                exp_q.push_back({7'(s * 11 + i), v});
                i++;
            end
            @(negedge clk);
            n++;
        end
        coef_valid = 1'b0;
        chk("stp_cycles", n, exp_len);
        chk("stp_done", done, 1);
        chk("stp_busy_done", busy, 1);
        chk("stp_ready_done", coef_ready, 0);
        @(negedge clk);
        chk("stp_busy_after", busy, 0);
        chk("stp_done_after", done, 0);
        chk("stp_drain", exp_q.size(), 0);
        chk("stp_done_cnt", done_cnt - d0, 1);
    endtask

    initial begin
        int n;
        int w0;
        int d0;
        rst = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        instr = 2'b00;
        slot = 3'd0;
        degree = 4'd0;
        coef_data = 16'h0;
        coef_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", coef_ready, 0);
        chk("rst_wr_en", wr_en_S, 0);
        chk("rst_addr", wr_addr_S, 0);
        chk("rst_data", wr_data_S, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b1;
        coef_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_wr", wr_cnt, 0);

        stp(2, 3, 1'b0, 4);
        stp(7, 10, 1'b1, 21);

        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            instr = 2'b00;
            slot = (k == 0) ? 3'd0 : 3'd3;
            degree = (k == 0) ? 4'd11 : 4'd15;
            w0 = wr_cnt;
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse", error, 1);
            chk("err_busy", busy, 0);
            chk("err_wr", wr_en_S, 0);
            @(negedge clk);
            chk("err_clear", error, 0);
            chk("err_busy2", busy, 0);
            chk("err_no_wr", wr_cnt - w0, 0);
        end

        for (int s = 5; s < 8; s++) begin
            start2 = 1'b1;
            instr = 2'b00;
            slot = 3'(s);
            degree = 4'd2;
            @(negedge clk);
            start2 = 1'b0;
            chk("err5_pulse", error2, 1);
            chk("err5_busy", busy2, 0);
            chk("err5_wr", wr_en2, 0);
            @(negedge clk);
            chk("err5_clear", error2, 0);
        end

        w0 = wr_cnt;
        d0 = done_cnt;
        for (int a = 0; a < 88; a++) exp_q.push_back({7'(a), 16'h0});
        start = 1'b1;
        instr = 2'b11;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            start = (n == 40);
            instr = 2'b00;
            slot = 3'd1;
            degree = 4'd2;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("clr_done_cycle", n, 89);
        @(negedge clk);
        chk("clr_busy_after", busy, 0);
        chk("clr_drain", exp_q.size(), 0);
        chk("clr_wr_cnt", wr_cnt - w0, 88);
        chk("clr_done_cnt", done_cnt - d0, 1);

        for (int k = 0; k < 2; k++) begin
            w0 = wr_cnt;
            d0 = done_cnt;
            start = 1'b1;
            instr = (k == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            start = 1'b0;
            chk("ev_busy", busy, 0);
            chk("ev_ready", coef_ready, 0);
            chk("ev_error", error, 0);
            repeat (2) @(negedge clk);
            chk("ev_no_wr", wr_cnt - w0, 0);
            chk("ev_no_done", done_cnt - d0, 0);
        end

        start = 1'b1;
        instr = 2'b00;
        slot = 3'd4;
        degree = 4'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            coef_valid = 1'b1;
            coef_data = 16'(16'hA000 + i);
            exp_q.push_back({7'(44 + i), coef_data});
            @(negedge clk);
        end
        coef_valid = 1'b0;
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", coef_ready, 0);
        chk("abort_wr_en", wr_en_S, 0);
        chk("abort_addr", wr_addr_S, 0);
        chk("abort_data", wr_data_S, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_error", error, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_drain", exp_q.size(), 0);
        stp(4, 4, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
